// File: rtl/selecionar_ativo.sv
// -----------------------------------------------------------------------------
// selecionar_ativo
//
// Picks one active node whose criterion equals the global minimum criterion
// reported by an external classifier. On a request it pulses the classifier
// start, waits (bounded) for the classifier to finish, then scans the nodes
// one per cycle from index 0. The first match wins. The result is held valid
// until the consumer acknowledges it.
//
// Parameters
//   NUM_NA          number of nodes
//   ADR_WIDTH       width of the selected-node address (2**ADR_WIDTH >= NUM_NA)
//   CRITERIO_WIDTH  width of one node criterion
//   TIMEOUT         maximum number of cycles spent waiting for the classifier
//
// Ports
//   clk                   clock, rising edge
//   rst_n                 asynchronous active-low reset
//   sa_iniciar_in         request one selection (only sampled when idle)
//   na_ativo_in           per-node active flags, bit i = node i
//   na_criterio_in        packed node criteria, node i at [CRITERIO_WIDTH*i +: CRITERIO_WIDTH]
//   ca_pronto_in          classifier done (level)
//   ca_criterio_geral_in  minimum criterion over the active nodes
//   sa_ack_in             consumer accepts the current result
//   sa_atualizar_out      one-cycle classifier start pulse
//   sa_valido_out         result valid, held until acknowledged
//   sa_endereco_out       index of the selected node
//   sa_vazio_out          valid result carries no match
//   sa_erro_out           valid result is a classifier timeout
//   sa_ocupado_out        block is not idle
// -----------------------------------------------------------------------------
module selecionar_ativo #(
    parameter int NUM_NA         = 8,
    parameter int ADR_WIDTH      = 8,
    parameter int CRITERIO_WIDTH = 5,
    parameter int TIMEOUT        = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             sa_iniciar_in,
    input  logic [NUM_NA-1:0]                na_ativo_in,
    input  logic [NUM_NA*CRITERIO_WIDTH-1:0] na_criterio_in,
    input  logic                             ca_pronto_in,
    input  logic [CRITERIO_WIDTH-1:0]        ca_criterio_geral_in,
    input  logic                             sa_ack_in,
    output logic                             sa_atualizar_out,
    output logic                             sa_valido_out,
    output logic [ADR_WIDTH-1:0]             sa_endereco_out,
    output logic                             sa_vazio_out,
    output logic                             sa_erro_out,
    output logic                             sa_ocupado_out
);

    // Counter must be able to hold TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        ATUALIZAR = 3'd1,
        AGUARDAR  = 3'd2,
        BUSCAR    = 3'd3,
        ENTREGAR  = 3'd4
    } estado_t;

    estado_t                     estado_r;
    estado_t                     estado_nx_s;
    logic [ADR_WIDTH-1:0]        idx_r;
    logic [ADR_WIDTH-1:0]        idx_nx_s;
    logic [CNT_W-1:0]            cnt_r;
    logic [CNT_W-1:0]            cnt_nx_s;
    logic [ADR_WIDTH-1:0]        endereco_r;
    logic [ADR_WIDTH-1:0]        endereco_nx_s;
    logic                        vazio_r;
    logic                        vazio_nx_s;
    logic                        erro_r;
    logic                        erro_nx_s;
    logic                        valido_r;
    logic                        atualizar_r;
    logic                        ocupado_r;

    logic                        ativo_sel_s;
    logic [CRITERIO_WIDTH-1:0]   crit_sel_s;
    logic                        match_s;
    logic                        ultimo_s;

    // Multiplex the node currently addressed by the scan index.
    always_comb begin
        ativo_sel_s = 1'b0;
        crit_sel_s  = '0;
        for (int i = 0; i < NUM_NA; i++) begin
            ativo_sel_s = (idx_r == ADR_WIDTH'(i)) ? na_ativo_in[i] : ativo_sel_s;
            crit_sel_s  = (idx_r == ADR_WIDTH'(i))
                        ? na_criterio_in[CRITERIO_WIDTH*i +: CRITERIO_WIDTH]
                        : crit_sel_s;
        end
        match_s  = ativo_sel_s && (crit_sel_s == ca_criterio_geral_in);
        ultimo_s = (idx_r == ADR_WIDTH'(NUM_NA - 1));
    end

    // Next-state and next-result logic of the selection FSM.
    always_comb begin
        estado_nx_s   = estado_r;
        idx_nx_s      = idx_r;
        cnt_nx_s      = cnt_r;
        endereco_nx_s = endereco_r;
        vazio_nx_s    = vazio_r;
        erro_nx_s     = erro_r;
        case (estado_r)
            OCIOSO: begin
                if (sa_iniciar_in) begin
                    estado_nx_s = ATUALIZAR;
                end else begin
                    estado_nx_s = OCIOSO;
                end
            end
            ATUALIZAR: begin
                cnt_nx_s      = '0;
                idx_nx_s      = '0;
                endereco_nx_s = '0;
                vazio_nx_s    = 1'b0;
                erro_nx_s     = 1'b0;
                estado_nx_s   = AGUARDAR;
            end
            AGUARDAR: begin
                if (ca_pronto_in) begin
                    estado_nx_s = BUSCAR;
                end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                    // Classifier never answered: deliver an error result.
                    estado_nx_s   = ENTREGAR;
                    endereco_nx_s = '0;
                    vazio_nx_s    = 1'b0;
                    erro_nx_s     = 1'b1;
                end else begin
                    cnt_nx_s = cnt_r + CNT_W'(1);
                end
            end
            BUSCAR: begin
                if (match_s) begin
                    // First match ends the scan, so the lowest index wins.
                    estado_nx_s   = ENTREGAR;
                    endereco_nx_s = idx_r;
                    vazio_nx_s    = 1'b0;
                    erro_nx_s     = 1'b0;
                end else if (ultimo_s) begin
                    estado_nx_s   = ENTREGAR;
                    endereco_nx_s = '0;
                    vazio_nx_s    = 1'b1;
                    erro_nx_s     = 1'b0;
                end else begin
                    idx_nx_s = idx_r + ADR_WIDTH'(1);
                end
            end
            ENTREGAR: begin
                if (sa_ack_in) begin
                    // A simultaneous request is dropped; only idle samples it.
                    estado_nx_s   = OCIOSO;
                    endereco_nx_s = '0;
                    vazio_nx_s    = 1'b0;
                    erro_nx_s     = 1'b0;
                end else begin
                    estado_nx_s = ENTREGAR;
                end
            end
            default: begin
                estado_nx_s   = OCIOSO;
                idx_nx_s      = '0;
                cnt_nx_s      = '0;
                endereco_nx_s = '0;
                vazio_nx_s    = 1'b0;
                erro_nx_s     = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs; outputs follow the next state
    // so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_r    <= OCIOSO;
            idx_r       <= '0;
            cnt_r       <= '0;
            endereco_r  <= '0;
            vazio_r     <= 1'b0;
            erro_r      <= 1'b0;
            valido_r    <= 1'b0;
            atualizar_r <= 1'b0;
            ocupado_r   <= 1'b0;
        end else begin
            estado_r    <= estado_nx_s;
            idx_r       <= idx_nx_s;
            cnt_r       <= cnt_nx_s;
            endereco_r  <= endereco_nx_s;
            vazio_r     <= vazio_nx_s;
            erro_r      <= erro_nx_s;
            valido_r    <= (estado_nx_s == ENTREGAR);
            atualizar_r <= (estado_nx_s == ATUALIZAR);
            ocupado_r   <= (estado_nx_s != OCIOSO);
        end
    end

    assign sa_atualizar_out = atualizar_r;
    assign sa_valido_out    = valido_r;
    assign sa_endereco_out  = endereco_r;
    assign sa_vazio_out     = vazio_r;
    assign sa_erro_out      = erro_r;
    assign sa_ocupado_out   = ocupado_r;

endmodule

// File: tb/tb_selecionar_ativo.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for selecionar_ativo (NUM_NA=8, CRITERIO_WIDTH=5,
// TIMEOUT=32). Expected results are queued when a selection is launched and
// popped when sa_valido_out rises.
// -----------------------------------------------------------------------------
module tb_selecionar_ativo;

    localparam int NA  = 8;
    localparam int AW  = 8;
    localparam int CW  = 5;
    localparam int TO  = 32;

    // Node 0 in the low bits: {9,4,7,4,12,3,3,20}.
    localparam logic [NA*CW-1:0] CRIT_A = {5'd20, 5'd3, 5'd3, 5'd12, 5'd4, 5'd7, 5'd4, 5'd9};
    localparam logic [NA*CW-1:0] CRIT_6 = {8{5'd6}};

    logic               clk;
    logic               rst_n;
    logic               sa_iniciar_in;
    logic [NA-1:0]      na_ativo_in;
    logic [NA*CW-1:0]   na_criterio_in;
    logic               ca_pronto_in;
    logic [CW-1:0]      ca_criterio_geral_in;
    logic               sa_ack_in;
    logic               sa_atualizar_out;
    logic               sa_valido_out;
    logic [AW-1:0]      sa_endereco_out;
    logic               sa_vazio_out;
    logic               sa_erro_out;
    logic               sa_ocupado_out;

    typedef struct packed {
        logic [AW-1:0] adr;
        logic          vazio;
        logic          erro;
    } res_t;

    res_t sb[$];
    int   total  = 0;
    int   bad    = 0;
    int   pulses = 0;
    int   n      = 0;

    selecionar_ativo #(
        .NUM_NA         (NA),
        .ADR_WIDTH      (AW),
        .CRITERIO_WIDTH (CW),
        .TIMEOUT        (TO)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .sa_iniciar_in        (sa_iniciar_in),
        .na_ativo_in          (na_ativo_in),
        .na_criterio_in       (na_criterio_in),
        .ca_pronto_in         (ca_pronto_in),
        .ca_criterio_geral_in (ca_criterio_geral_in),
        .sa_ack_in            (sa_ack_in),
        .sa_atualizar_out     (sa_atualizar_out),
        .sa_valido_out        (sa_valido_out),
        .sa_endereco_out      (sa_endereco_out),
        .sa_vazio_out         (sa_vazio_out),
        .sa_erro_out          (sa_erro_out),
        .sa_ocupado_out       (sa_ocupado_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {19'd0, sa_atualizar_out, sa_valido_out, sa_endereco_out,
                sa_vazio_out, sa_erro_out, sa_ocupado_out};
    endfunction

    // Start a selection, queue its expected result, check the start pulse.
    task automatic launch(input logic [AW-1:0] adr, input logic vz, input logic er,
                          input bit hold, input string tag);
        res_t r;
        r.adr   = adr;
        r.vazio = vz;
        r.erro  = er;
        sb.push_back(r);
        sa_iniciar_in = 1'b1;
        step();
        chk({tag, "_atualizar_on"}, {31'd0, sa_atualizar_out}, 32'd1);
        chk({tag, "_ocupado"},      {31'd0, sa_ocupado_out},   32'd1);
        if (!hold) sa_iniciar_in = 1'b0;
        step();
        chk({tag, "_atualizar_off"}, {31'd0, sa_atualizar_out}, 32'd0);
        chk({tag, "_valido_low"},    {31'd0, sa_valido_out},    32'd0);
    endtask

    // Wait (bounded) for a valid result, counting start pulses seen meanwhile.
    task automatic wait_valid(input int max_c, output int cycles);
        cycles = 0;
        while (!sa_valido_out && cycles < max_c) begin
            step();
            cycles++;
            if (sa_atualizar_out) pulses++;
        end
    endtask

    task automatic check_result(input string tag);
        res_t r;
        chk({tag, "_valido"}, {31'd0, sa_valido_out}, 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_entry"}, sb.size(), 32'd1);
        end else begin
            r = sb.pop_front();
            chk({tag, "_endereco"}, {24'd0, sa_endereco_out}, {24'd0, r.adr});
            chk({tag, "_vazio"},    {31'd0, sa_vazio_out},    {31'd0, r.vazio});
            chk({tag, "_erro"},     {31'd0, sa_erro_out},     {31'd0, r.erro});
        end
    endtask

    // Let the classifier finish after wait_c cycles, then time the scan.
    task automatic finish_run(input int wait_c, input int exp_lat, input string tag);
        repeat (wait_c) step();
        ca_pronto_in = 1'b1;
        step();
        ca_pronto_in = 1'b0;
        wait_valid(4 * TO, n);
        chk({tag, "_latency"}, n, exp_lat);
        check_result(tag);
    endtask

    task automatic do_ack(input string tag);
        sa_ack_in = 1'b1;
        step();
        sa_ack_in = 1'b0;
        chk({tag, "_ack_valido"},  {31'd0, sa_valido_out},  32'd0);
        chk({tag, "_ack_ocupado"}, {31'd0, sa_ocupado_out}, 32'd0);
    endtask

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n                = 1'b0;
        sa_iniciar_in        = 1'b0;
        na_ativo_in          = '0;
        na_criterio_in       = '0;
        ca_pronto_in         = 1'b0;
        ca_criterio_geral_in = '0;
        sa_ack_in            = 1'b0;
        repeat (3) step();
        chk("reset_outputs", all_outs(), 32'd0);
        rst_n = 1'b1;
        step();
        chk("idle_outputs", all_outs(), 32'd0);

        // Match at index 5, result held until acknowledged.
        na_ativo_in          = 8'b0110_0101;
        na_criterio_in       = CRIT_A;
        ca_criterio_geral_in = 5'd3;
        launch(8'd5, 1'b0, 1'b0, 1'b0, "t1");
        finish_run(7, 6, "t1");
        ca_pronto_in = 1'b1;
        repeat (3) step();
        ca_pronto_in = 1'b0;
        chk("t1_hold_valido",   {31'd0, sa_valido_out},   32'd1);
        chk("t1_hold_endereco", {24'd0, sa_endereco_out}, 32'd5);
        do_ack("t1");

        // Tie: lowest index wins, valid one cycle after the scan starts.
        na_ativo_in          = 8'hFF;
        na_criterio_in       = CRIT_6;
        ca_criterio_geral_in = 5'd6;
        launch(8'd0, 1'b0, 1'b0, 1'b0, "t2");
        finish_run(2, 1, "t2");
        do_ack("t2");

        // No match; ack while waiting has no effect.
        na_ativo_in          = 8'h00;
        na_criterio_in       = CRIT_A;
        ca_criterio_geral_in = 5'd9;
        launch(8'd0, 1'b1, 1'b0, 1'b0, "t3");
        sa_ack_in = 1'b1;
        repeat (3) step();
        sa_ack_in = 1'b0;
        chk("t3_ack_ignored_ocupado", {31'd0, sa_ocupado_out}, 32'd1);
        chk("t3_ack_ignored_valido",  {31'd0, sa_valido_out},  32'd0);
        finish_run(0, 8, "t3");
        do_ack("t3");

        // Timeout with the request held high the whole time.
        launch(8'd0, 1'b0, 1'b1, 1'b1, "t4");
        pulses = 1;
        wait_valid(4 * TO, n);
        chk("t4_timeout_cycles", n, TO);
        chk("t4_single_pulse", pulses, 32'd1);
        check_result("t4");
        sa_ack_in = 1'b1;
        step();
        sa_ack_in = 1'b0;
        chk("t4_ack_valido",    {31'd0, sa_valido_out},    32'd0);
        chk("t4_ack_ocupado",   {31'd0, sa_ocupado_out},   32'd0);
        chk("t4_req_dropped",   {31'd0, sa_atualizar_out}, 32'd0);
        step();
        chk("t4_restart_idle",  {31'd0, sa_atualizar_out}, 32'd1);
        sa_iniciar_in = 1'b0;
        sb.push_back('{adr: 8'd0, vazio: 1'b1, erro: 1'b0});

        // Reset in the middle of the scan (index 3).
        step();
        chk("t5_aguardar", {31'd0, sa_atualizar_out}, 32'd0);
        ca_pronto_in = 1'b1;
        step();
        ca_pronto_in = 1'b0;
        repeat (3) step();
        chk("t5_scanning", {31'd0, sa_ocupado_out}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_reset", all_outs(), 32'd0);
        sb.delete();
        step();
        chk("t5_reset_held", all_outs(), 32'd0);
        rst_n = 1'b1;

        // Fresh run right after release.
        na_ativo_in          = 8'b0110_0101;
        na_criterio_in       = CRIT_A;
        ca_criterio_geral_in = 5'd3;
        launch(8'd5, 1'b0, 1'b0, 1'b0, "t6");
        finish_run(2, 6, "t6");
        do_ack("t6");

        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
